// File: rtl/pcs_pkg.sv
// Shared definitions for the 10GBASE-R PCS transmit path: sync header codes,
// gearbox sequence limit, the 66-bit block type and a header-corruption helper.
package pcs_pkg;

   localparam logic [1:0] SYNC_CTRL       = 2'b10;
   localparam logic [1:0] SYNC_DATA       = 2'b01;
   localparam logic [5:0] GEARBOX_SEQ_MAX = 6'd32;

   // 66-bit block; head sits in the two LSBs and is transmitted first.
   typedef struct packed {
      logic [63:0] data;
      logic [1:0]  head;
   } block_t;

   // Forces a header into one of the two invalid codes (00 or 11).
   function automatic logic [1:0] sh_corrupt(input logic [1:0] head);
      return {head[0], head[0]};
   endfunction

endpackage

// File: rtl/pcs_gearbox_tx_shift.sv
// Combinational 66b->64b datapath: merges the incoming block above the residue
// bits with a single 128-bit shift of 2k, then splits the result into the
// outgoing word (low 64 bits) and the new residue (high 64 bits).
module pcs_gearbox_tx_shift
   import pcs_pkg::*;
(
   input  block_t      blk_i,
   input  logic [63:0] res_i,
   input  logic [4:0]  k_i,
   output logic [63:0] word_o,
   output logic [63:0] res_next_o
);

   logic [127:0] cat_s;

   // Place the block at bit 2k on top of the 2k residue bits.
   always_comb begin
      cat_s      = ({62'd0, blk_i} << {k_i, 1'b0}) | {64'd0, res_i};
      word_o     = cat_s[63:0];
      res_next_o = cat_s[127:64];
   end

endmodule

// File: rtl/pcs_gearbox_tx.sv
// TX 66b->64b gearbox. Consumes one block per cycle for 32 cycles, then stalls
// one cycle to flush the accumulated 64 header bits as a full word.
// Optional feature macro: PCS_TX_SH_ERR_INJ_EN adds sh_err_i, which replaces
// the header of an accepted block with an invalid code (00/11).
module pcs_gearbox_tx
   import pcs_pkg::*;
#(
   parameter int HEAD_W = 2,
   parameter int DATA_W = 64,
   parameter int SEQ_W  = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [HEAD_W-1:0] head_i,
   input  logic [DATA_W-1:0] data_i,
`ifdef PCS_TX_SH_ERR_INJ_EN
   input  logic              sh_err_i,
`endif
   output logic              ready_o,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o,
   output logic [SEQ_W-1:0]  seq_o
);

   logic [SEQ_W-1:0]  seq_q, seq_d;
   logic [63:0]       res_q, res_d;
   logic [63:0]       data_q, data_d;
   logic              valid_q;
   logic              ready_s;
   logic [1:0]        head_s;
   block_t            blk_s;
   logic [63:0]       word_s;
   logic [63:0]       res_next_s;

   assign ready_s = (seq_q != GEARBOX_SEQ_MAX);

   // Select the transmitted header, optionally corrupted for RX slip testing.
   always_comb begin
`ifdef PCS_TX_SH_ERR_INJ_EN
      if (sh_err_i) begin
         head_s = sh_corrupt(head_i);
      end else begin
         head_s = head_i;
      end
`else
      head_s = head_i;
`endif
      blk_s.head = head_s;
      blk_s.data = data_i;
   end

   pcs_gearbox_tx_shift u_shift (
      .blk_i      (blk_s),
      .res_i      (res_q),
      .k_i        (seq_q[4:0]),
      .word_o     (word_s),
      .res_next_o (res_next_s)
   );

   // Next-state: consume a block while seq<32, otherwise flush the residue.
   always_comb begin
      seq_d  = seq_q;
      res_d  = res_q;
      data_d = data_q;
      if (ready_s) begin
         data_d = word_s;
         res_d  = res_next_s;
         seq_d  = seq_q + SEQ_W'(1);
      end else begin
         data_d = res_q;
         res_d  = 64'd0;
         seq_d  = {SEQ_W{1'b0}};
      end
   end

   // State registers; reset drops residue and restarts block-aligned.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seq_q   <= {SEQ_W{1'b0}};
         res_q   <= 64'd0;
         data_q  <= 64'd0;
         valid_q <= 1'b0;
      end else begin
         seq_q   <= seq_d;
         res_q   <= res_d;
         data_q  <= data_d;
         valid_q <= 1'b1;
      end
   end

   assign ready_o = ready_s;
   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign seq_o   = seq_q;

endmodule

// File: tb/tb_pcs_gearbox_tx.sv
// Directed bench for pcs_gearbox_tx: zero-payload header walk, random-block
// stream reassembly, asynchronous reset mid-sequence, header injection.
module tb_pcs_gearbox_tx;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  head_i;
   logic [63:0] data_i;
   logic        sh_err_i;
   logic        ready_o;
   logic        valid_o;
   logic [63:0] data_o;
   logic [5:0]  seq_o;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pcs_gearbox_tx dut (
      .clk      (clk),
      .reset    (reset),
      .head_i   (head_i),
      .data_i   (data_i),
`ifdef PCS_TX_SH_ERR_INJ_EN
      .sh_err_i (sh_err_i),
`endif
      .ready_o  (ready_o),
      .valid_o  (valid_o),
      .data_o   (data_o),
      .seq_o    (seq_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      logic        q[$];
      logic [65:0] blk;
      logic [63:0] w;
      logic [63:0] prev_data;
      logic        rdy;
      int          stalls;
      int          blocks;
      bit          found;

      reset    = 1'b1;
      head_i   = 2'b00;
      data_i   = 64'd0;
      sh_err_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_seq",   64'(seq_o),   64'd0);
      chk("rst_valid", 64'(valid_o), 64'd0);
      chk("rst_data",  data_o,       64'd0);
      chk("rst_ready", 64'(ready_o), 64'd1);
      reset = 1'b0;

      // Phase 1: 32 zero-payload data blocks; header walks up by 2 bits/word.
      for (int c = 0; c < 33; c++) begin
         chk("p1_seq",   64'(seq_o),   64'(c));
         chk("p1_ready", 64'(ready_o), (c == 32) ? 64'd0 : 64'd1);
         head_i = 2'b01;
         data_i = 64'd0;
         @(posedge clk);
         #1;
         chk("p1_valid", 64'(valid_o), 64'd1);
         chk("p1_word",  data_o, (c < 32) ? (64'd1 << (2 * c)) : 64'd0);
      end

      // Phase 2: 96 random blocks; bit-queue model of the serial stream.
      stalls = 0;
      blocks = 0;
      for (int c = 0; c < 99; c++) begin
         rdy = ready_o;
         if (rdy) begin
            head_i = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            data_i = {$urandom, $urandom};
            blk    = {data_i, head_i};
            for (int i = 0; i < 66; i++) q.push_back(blk[i]);
            blocks++;
         end else begin
            stalls++;
         end
         @(posedge clk);
         #1;
         if (q.size() >= 64) begin
            for (int i = 0; i < 64; i++) w[i] = q.pop_front();
            chk("p2_word", data_o, w);
         end else begin
            chk("p2_queue_underrun", 64'(q.size()), 64'd64);
         end
      end
      chk("p2_stalls", 64'(stalls), 64'd3);
      chk("p2_blocks", 64'(blocks), 64'd96);
      chk("p2_drain",  64'(q.size()), 64'd0);

      // Phase 3: asynchronous reset at seq=17.
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         if (seq_o == 6'd17) begin
            found = 1'b1;
         end else begin
            head_i = 2'b01;
            data_i = 64'd0;
            @(posedge clk);
            #1;
         end
      end
      chk("p3_reach_17", 64'(found), 64'd1);
      reset = 1'b1;
      #1;
      chk("p3_async_seq",   64'(seq_o),   64'd0);
      chk("p3_async_valid", 64'(valid_o), 64'd0);
      chk("p3_async_data",  data_o,       64'd0);
      @(posedge clk);
      #1;
      reset  = 1'b0;
      head_i = 2'b10;
      data_i = 64'hA5A5_0F0F_1234_5678;
      blk    = {data_i, head_i};
      prev_data = data_i;
      @(posedge clk);
      #1;
      chk("p3_realign_word", data_o, blk[63:0]);
      chk("p3_seq1",   64'(seq_o),   64'd1);
      chk("p3_valid",  64'(valid_o), 64'd1);

      // Phase 4: header injection at seq=1 (header lands at bits 3:2).
      head_i   = 2'b01;
      data_i   = 64'd0;
      sh_err_i = 1'b1;
      @(posedge clk);
      #1;
      sh_err_i = 1'b0;
      chk("p4_residue", 64'(data_o[1:0]), 64'(prev_data[63:62]));
`ifdef PCS_TX_SH_ERR_INJ_EN
      chk("p4_hdr_injected", 64'(data_o[3:2]), 64'd3);
`else
      chk("p4_hdr_passthru", 64'(data_o[3:2]), 64'd1);
`endif
      chk("p4_payload", 64'(data_o[63:4]), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
